aeolus_control_unit: RTL

Fetch/decode/execute sequencer for the 4-bit Aeolus datapath. Sits directly upstream of the A/B/O register file. Fetches 8-bit instructions from a synchronous program ROM, decodes them, and drives the register-file load enables (LDA/LDB/LDO), operand-source selects and ALU op. Owns the program counter, the ALU status flags and the halt state.

---
 rtl/aeolus_pkg.sv | 44 ++++
 rtl/aeolus_if.sv | 38 +++
 rtl/aeolus_pc.sv | 34 +++
 rtl/aeolus_control_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/aeolus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aeolus_pkg
// Brief    : Shared opcodes, sequencer states and ALU op encodings for Aeolus.
// Revision : 1.0 - initial release
// ============================================================================
package aeolus_pkg;

  localparam int OPCODE_WIDTH = 4;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;

  localparam opcode_t OPC_NOP  = 4'h0;
  localparam opcode_t OPC_LDAI = 4'h1;
  localparam opcode_t OPC_LDBI = 4'h2;
  localparam opcode_t OPC_ADD  = 4'h3;
  localparam opcode_t OPC_SUB  = 4'h4;
  localparam opcode_t OPC_AND  = 4'h5;
  localparam opcode_t OPC_OR   = 4'h6;
  localparam opcode_t OPC_MOVA = 4'h7;
  localparam opcode_t OPC_MOVB = 4'h8;
  localparam opcode_t OPC_JMP  = 4'h9;
  localparam opcode_t OPC_JZ   = 4'hA;
  localparam opcode_t OPC_JC   = 4'hB;
  localparam opcode_t OPC_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  function automatic int instr_width(input int data_width);
    return OPCODE_WIDTH + data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aeolus_if.sv
`default_nettype none
// ============================================================================
// Module   : aeolus_if
// Brief    : ROM fetch and register-file control bundle of the Aeolus core.
// Revision : 1.0 - initial release
// ============================================================================
interface aeolus_if
  import aeolus_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
);

  logic [instr_width(DATA_WIDTH)-1:0] instr_in;
  logic                               alu_zero;
  logic                               alu_carry;
  logic [ADDR_WIDTH-1:0]              rom_addr;
  logic [DATA_WIDTH-1:0]              imm;
  logic                               a_src;
  logic                               b_src;
  logic [1:0]                         alu_op;
  logic                               LDA;
  logic                               LDB;
  logic                               LDO;
  logic                               halted;

  modport master (
    input  instr_in, alu_zero, alu_carry,
    output rom_addr, imm, a_src, b_src, alu_op, LDA, LDB, LDO, halted
  );

  modport slave (
    output instr_in, alu_zero, alu_carry,
    input  rom_addr, imm, a_src, b_src, alu_op, LDA, LDB, LDO, halted
  );

endinterface
`default_nettype wire

// File: rtl/aeolus_pc.sv
`default_nettype none
// ============================================================================
// Module   : aeolus_pc
// Brief    : Program counter with load / increment / hold; wraps modulo 2^N.
// Revision : 1.0 - initial release
// ============================================================================
module aeolus_pc #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_inc,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_val,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  logic [ADDR_WIDTH-1:0] r_pc;

  // Load wins over increment so a taken branch needs no separate inc gating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/aeolus_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : aeolus_control_unit
// Brief    : Fetch/decode/execute sequencer driving the Aeolus register file.
// Revision : 1.0 - initial release
// ============================================================================
module aeolus_control_unit
  import aeolus_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     run,
  aeolus_if.master bus
);

  localparam int C_IW = instr_width(DATA_WIDTH);

  state_t                r_state;
  state_t                w_next;
  logic [C_IW-1:0]       r_ir;
  logic                  r_z;
  logic                  r_c;
  opcode_t               w_opcode;
  logic [ADDR_WIDTH-1:0] w_pc;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_pc_inc;
  logic                  w_pc_load;
  logic                  w_flag_ld;
  logic                  w_lda;
  logic                  w_ldb;
  logic                  w_ldo;
  logic                  w_a_src;
  logic                  w_b_src;
  logic [1:0]            w_alu_op;
  logic                  w_halted;

  assign w_opcode = r_ir[C_IW-1 -: OPCODE_WIDTH];
  assign w_target = ADDR_WIDTH'(r_ir[DATA_WIDTH-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_ir <= bus.instr_in;
      end
      if (w_flag_ld) begin
        r_z <= bus.alu_zero;
        r_c <= bus.alu_carry;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_lda     = 1'b0;
    w_ldb     = 1'b0;
    w_ldo     = 1'b0;
    w_a_src   = 1'b0;
    w_b_src   = 1'b0;
    w_alu_op  = ALU_ADD;
    w_halted  = 1'b0;
    w_pc_inc  = 1'b0;
    w_pc_load = 1'b0;
    w_flag_ld = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (run) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        w_next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        w_next   = ST_FETCH;
        w_pc_inc = 1'b1;
        case (w_opcode)
          OPC_LDAI: w_lda = 1'b1;
          OPC_LDBI: w_ldb = 1'b1;
          OPC_ADD:  begin w_ldo = 1'b1; w_alu_op = ALU_ADD; w_flag_ld = 1'b1; end
          OPC_SUB:  begin w_ldo = 1'b1; w_alu_op = ALU_SUB; w_flag_ld = 1'b1; end
          OPC_AND:  begin w_ldo = 1'b1; w_alu_op = ALU_AND; w_flag_ld = 1'b1; end
          OPC_OR:   begin w_ldo = 1'b1; w_alu_op = ALU_OR;  w_flag_ld = 1'b1; end
          OPC_MOVA: begin w_lda = 1'b1; w_a_src = 1'b1; end
          OPC_MOVB: begin w_ldb = 1'b1; w_b_src = 1'b1; end
          OPC_JMP:  w_pc_load = 1'b1;
          OPC_JZ:   w_pc_load = r_z;
          OPC_JC:   w_pc_load = r_c;
          OPC_HALT: w_next = ST_HALT;
          default:  ;
        endcase
      end
      ST_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

  aeolus_pc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (w_pc_inc),
    .i_load     (w_pc_load),
    .i_load_val (w_target),
    .o_pc       (w_pc)
  );

  assign bus.rom_addr = w_pc;
  assign bus.imm      = r_ir[DATA_WIDTH-1:0];
  assign bus.a_src    = w_a_src;
  assign bus.b_src    = w_b_src;
  assign bus.alu_op   = w_alu_op;
  assign bus.LDA      = w_lda;
  assign bus.LDB      = w_ldb;
  assign bus.LDO      = w_ldo;
  assign bus.halted   = w_halted;

endmodule
`default_nettype wire
